// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//
// Shared definitions for the APB reference subsystem: bus widths, slave
// memory geometry and the master FSM state encoding.
//
// Contents:
//   ADDR_W     - APB address width (bit 8 selects the slave)
//   DATA_W     - APB data width
//   MEM_DEPTH  - words per slave memory
//   SLAVE_AW   - word index width inside one slave
//   apb_state_t - master FSM states IDLE / SETUP / ACCESS
//   slave_sel  - helper returning the slave-select bit of an address
// ---------------------------------------------------------------------------
package apb_pkg;

   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 256;
   localparam int SLAVE_AW  = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

   // The top address bit picks slave 2; everything below it is the word index.
   function automatic logic slave_sel(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1];
   endfunction

endpackage

// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//
// Zero-wait-state APB memory slave. Each word carries a valid bit that is
// set on the first write after reset; reading a word whose valid bit is
// clear returns zero data and raises PSLVERR. Memory contents survive reset,
// only the valid bits are cleared.
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETn  in   synchronous active-low reset
//   psel     in   slave selected
//   penable  in   ACCESS phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   word index
//   pwdata   in   write data
//   prdata   out  read data, valid combinationally during ACCESS
//   pready   out  always ready (no wait states)
//   pslverr  out  read of a never-written word
// ---------------------------------------------------------------------------
module apb_slave
   import apb_pkg::*;
(
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [SLAVE_AW-1:0] paddr,
   input  logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr
);

   logic [DATA_W-1:0]    mem [MEM_DEPTH];
   logic [MEM_DEPTH-1:0] valid;
   logic                 wr_commit;
   logic                 rd_access;

   // A write commits on the edge that ends ACCESS; a reset on that same edge
   // wins, so an in-flight write is dropped.
   assign wr_commit = PRESETn & psel & penable & pwrite;
   assign rd_access = psel & penable & ~pwrite;
   assign pready    = 1'b1;

   // Storage array deliberately has no reset so it maps onto plain RAM.
   always_ff @(posedge PCLK) begin
      if (wr_commit) begin
         mem[paddr] <= pwdata;
      end
   end

   // Valid bits track which words have been written since the last reset.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         valid <= '0;
      end else if (wr_commit) begin
         valid[paddr] <= 1'b1;
      end
   end

   // Read path: stale memory content is masked to zero when the word is not
   // valid, and the error flag is raised instead.
   always_comb begin
      prdata  = '0;
      pslverr = 1'b0;
      if (rd_access) begin
         if (valid[paddr]) begin
            prdata = mem[paddr];
         end else begin
            pslverr = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_protocol.sv
// ---------------------------------------------------------------------------
// apb_protocol
//
// APB master plus two memory-backed APB slaves. A simple request interface
// (transfer / READ_WRITE / addresses / data) is turned into SETUP and ACCESS
// phases. Address bit 8 picks slave 1 (0) or slave 2 (1). The result of each
// completed transfer is registered on the user side and held until the next
// transfer completes.
//
// Ports:
//   PCLK               in   clock, rising edge
//   PRESETn            in   synchronous active-low reset
//   transfer           in   request enable, back-to-back while high
//   READ_WRITE         in   0 = write, 1 = read
//   apb_write_paddr    in   write address
//   apb_write_data     in   write data
//   apb_read_paddr     in   read address
//   PSLVERR            out  error of the last completed transfer
//   apb_read_data_out  out  data of the last completed read
// ---------------------------------------------------------------------------
module apb_protocol
   import apb_pkg::*;
(
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              transfer,
   input  logic              READ_WRITE,
   input  logic [ADDR_W-1:0] apb_write_paddr,
   input  logic [DATA_W-1:0] apb_write_data,
   input  logic [ADDR_W-1:0] apb_read_paddr,
   output logic              PSLVERR,
   output logic [DATA_W-1:0] apb_read_data_out
);

   apb_state_t state;
   apb_state_t state_next;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;

   logic              psel1;
   logic              psel2;
   logic [DATA_W-1:0] prdata1;
   logic [DATA_W-1:0] prdata2;
   logic              pready1;
   logic              pready2;
   logic              pslverr1;
   logic              pslverr2;

   logic [DATA_W-1:0] prdata_sel;
   logic              pready_sel;
   logic              pslverr_sel;
   logic              xfer_done;

   // Master state register.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and phase outputs. transfer is only looked at in IDLE and at
   // the end of ACCESS, so dropping it during SETUP still lets ACCESS finish.
   always_comb begin
      state_next = state;
      psel       = 1'b0;
      penable    = 1'b0;
      case (state)
         IDLE: begin
            if (transfer) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            psel       = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready_sel) begin
               state_next = transfer ? SETUP : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request capture happens only on the edge entering SETUP, which keeps
   // address, direction and data stable across the whole ACCESS phase even
   // if the user inputs move.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
      end else if (state_next == SETUP) begin
         pwrite <= ~READ_WRITE;
         paddr  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
         pwdata <= apb_write_data;
      end
   end

   // Exactly one slave sees PSEL for any given transfer.
   assign psel1 = psel & ~slave_sel(paddr);
   assign psel2 = psel &  slave_sel(paddr);

   apb_slave u_slave1 (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .psel    (psel1),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr[SLAVE_AW-1:0]),
      .pwdata  (pwdata),
      .prdata  (prdata1),
      .pready  (pready1),
      .pslverr (pslverr1)
   );

   apb_slave u_slave2 (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .psel    (psel2),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr[SLAVE_AW-1:0]),
      .pwdata  (pwdata),
      .prdata  (prdata2),
      .pready  (pready2),
      .pslverr (pslverr2)
   );

   // Return-path mux follows the registered address, not the select lines,
   // so it is stable for the whole transfer.
   always_comb begin
      if (slave_sel(paddr)) begin
         prdata_sel  = prdata2;
         pready_sel  = pready2;
         pslverr_sel = pslverr2;
      end else begin
         prdata_sel  = prdata1;
         pready_sel  = pready1;
         pslverr_sel = pslverr1;
      end
   end

   assign xfer_done = (state == ACCESS) & pready_sel;

   // User-side result registers: error updates on every completed transfer,
   // read data only on reads so a write leaves the last read value visible.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PSLVERR           <= 1'b0;
         apb_read_data_out <= '0;
      end else if (xfer_done) begin
         PSLVERR <= pslverr_sel;
         if (!pwrite) begin
            apb_read_data_out <= prdata_sel;
         end
      end
   end

endmodule

// File: tb/tb_apb_protocol.sv
// ---------------------------------------------------------------------------
// tb_apb_protocol
//
// Directed bench for apb_protocol: bursts of back-to-back writes and reads
// on both slaves, single transfers with transfer dropped in SETUP, reads of
// never-written words, and reset in the middle of a write.
// ---------------------------------------------------------------------------
module tb_apb_protocol;

   logic       PCLK;
   logic       PRESETn;
   logic       transfer;
   logic       READ_WRITE;
   logic [8:0] apb_write_paddr;
   logic [7:0] apb_write_data;
   logic [8:0] apb_read_paddr;
   logic       PSLVERR;
   logic [7:0] apb_read_data_out;

   int errors;
   int checks;

   apb_protocol dut (
      .PCLK              (PCLK),
      .PRESETn           (PRESETn),
      .transfer          (transfer),
      .READ_WRITE        (READ_WRITE),
      .apb_write_paddr   (apb_write_paddr),
      .apb_write_data    (apb_write_data),
      .apb_read_paddr    (apb_read_paddr),
      .PSLVERR           (PSLVERR),
      .apb_read_data_out (apb_read_data_out)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
      end
   endtask

   // Loads the request inputs. The unused address port gets the inverted
   // address so a wrong address mux lands on a different word or slave.
   task automatic setInputs(input logic rd, input logic [8:0] addr,
                            input logic [7:0] data);
      READ_WRITE = rd;
      apb_write_data = data;
      if (rd) begin
         apb_read_paddr  = addr;
         apb_write_paddr = ~addr;
      end else begin
         apb_write_paddr = addr;
         apb_read_paddr  = ~addr;
      end
   endtask

   task automatic stepEdge();
      @(posedge PCLK);
      #1;
   endtask

   task automatic applyReset();
      PRESETn  = 1'b0;
      transfer = 1'b0;
      stepEdge();
      stepEdge();
      PRESETn = 1'b1;
   endtask

   // One transfer with transfer dropped right after SETUP is entered, so the
   // FSM must finish ACCESS on its own and then return to IDLE.
   task automatic applyStimulus(input logic rd, input logic [8:0] addr,
                                input logic [7:0] data);
      setInputs(rd, addr, data);
      transfer = 1'b1;
      stepEdge();
      transfer = 1'b0;
      setInputs(~rd, ~addr, ~data);
      stepEdge();
      stepEdge();
   endtask

   // Eight back-to-back transfers at base+i with write data i*scale. Phase
   // checks confirm a strict SETUP/ACCESS rhythm, i.e. one transfer per two
   // cycles; results are checked after each completion edge.
   task automatic applyBurst(input string name, input logic rd,
                             input logic [8:0] base, input int scale,
                             input logic expErr);
      setInputs(rd, base, 8'(0));
      transfer = 1'b1;
      stepEdge();
      for (int i = 0; i < 8; i++) begin
         checkOutput({name, "_setup_phase"}, {30'd0, dut.psel, dut.penable}, 32'h2);
         stepEdge();
         checkOutput({name, "_access_phase"}, {30'd0, dut.psel, dut.penable}, 32'h3);
         if (i < 7) begin
            setInputs(rd, base + 9'(i + 1), 8'((i + 1) * scale));
         end else begin
            transfer = 1'b0;
         end
         stepEdge();
         checkOutput({name, "_err"}, {31'd0, PSLVERR}, {31'd0, expErr});
         if (rd) begin
            checkOutput({name, "_data"}, {24'd0, apb_read_data_out},
                        expErr ? 32'h0 : 32'(8'(i * scale)));
         end
      end
      checkOutput({name, "_idle_after"}, {30'd0, dut.psel, dut.penable}, 32'h0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      setInputs(1'b0, 9'h000, 8'h00);
      applyReset();

      checkOutput("reset_err",  {31'd0, PSLVERR}, 32'h0);
      checkOutput("reset_data", {24'd0, apb_read_data_out}, 32'h0);
      checkOutput("reset_idle", {30'd0, dut.psel, dut.penable}, 32'h0);

      // Slave 1 writes 2*i, then read back; slave 2 writes i, then read back.
      applyBurst("s1_wr", 1'b0, 9'h000, 2, 1'b0);
      applyBurst("s1_rd", 1'b1, 9'h000, 2, 1'b0);
      applyBurst("s2_wr", 1'b0, 9'h100, 1, 1'b0);
      applyBurst("s2_rd", 1'b1, 9'h100, 1, 1'b0);

      // Reset clears the valid bits, so earlier writes read back as errors.
      applyReset();
      applyBurst("s1_rd_after_rst", 1'b1, 9'h000, 2, 1'b1);

      // Single write then read of the same word; a write keeps the last data.
      applyStimulus(1'b0, 9'h00E, 8'h09);
      checkOutput("wr_0e_err", {31'd0, PSLVERR}, 32'h0);
      applyStimulus(1'b1, 9'h00E, 8'h00);
      checkOutput("rd_0e_err",  {31'd0, PSLVERR}, 32'h0);
      checkOutput("rd_0e_data", {24'd0, apb_read_data_out}, 32'h09);
      applyStimulus(1'b0, 9'h00F, 8'h33);
      checkOutput("wr_0f_err",  {31'd0, PSLVERR}, 32'h0);
      checkOutput("wr_0f_hold", {24'd0, apb_read_data_out}, 32'h09);
      applyStimulus(1'b1, 9'h02D, 8'h00);
      checkOutput("rd_2d_err",  {31'd0, PSLVERR}, 32'h1);
      checkOutput("rd_2d_data", {24'd0, apb_read_data_out}, 32'h0);

      // Reset lands on the edge that would end ACCESS of a write to 0x016.
      setInputs(1'b0, 9'h016, 8'h77);
      transfer = 1'b1;
      stepEdge();
      transfer = 1'b0;
      stepEdge();
      checkOutput("mid_rst_access", {30'd0, dut.psel, dut.penable}, 32'h3);
      PRESETn = 1'b0;
      stepEdge();
      PRESETn = 1'b1;
      checkOutput("mid_rst_idle", {30'd0, dut.psel, dut.penable}, 32'h0);
      checkOutput("mid_rst_err",  {31'd0, PSLVERR}, 32'h0);
      applyStimulus(1'b1, 9'h016, 8'h00);
      checkOutput("rd_16_err",  {31'd0, PSLVERR}, 32'h1);
      checkOutput("rd_16_data", {24'd0, apb_read_data_out}, 32'h0);

      // Fresh write then read on slave 2, then idle: outputs must hold.
      applyStimulus(1'b0, 9'h1AB, 8'h5C);
      checkOutput("wr_1ab_err", {31'd0, PSLVERR}, 32'h0);
      applyStimulus(1'b1, 9'h1AB, 8'h00);
      checkOutput("rd_1ab_err",  {31'd0, PSLVERR}, 32'h0);
      checkOutput("rd_1ab_data", {24'd0, apb_read_data_out}, 32'h5C);
      for (int i = 0; i < 3; i++) begin
         stepEdge();
      end
      checkOutput("hold_idle", {30'd0, dut.psel, dut.penable}, 32'h0);
      checkOutput("hold_err",  {31'd0, PSLVERR}, 32'h0);
      checkOutput("hold_data", {24'd0, apb_read_data_out}, 32'h5C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_protocol.md
# apb_protocol

Self-contained APB subsystem: an APB master converting a simple user request interface (transfer / direction / address / data) into APB SETUP/ACCESS phases, driving two identical memory-backed APB slaves selected by address bit 8. Read data and slave error are returned to the user side. Used as a standalone APB reference block and bring-up vehicle.

## Interface
- No parameters. Fixed: address 9 bits, data 8 bits, 2 slaves × 256 × 8 memory.
- PCLK  in  1  single clock, all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- transfer  in  1  request enable; while high, back-to-back transfers are issued.
- READ_WRITE  in  1  direction: 0 = write, 1 = read.
- apb_write_paddr  in  9  write address; bit 8 selects slave (0 → slave 1, 1 → slave 2), bits 7:0 = word index.
- apb_write_data  in  8  write data.
- apb_read_paddr  in  9  read address, same split.
- PSLVERR  out  1  error of the most recently completed transfer.
- apb_read_data_out  out  8  data of the most recently completed read.

## Operation
- Master FSM states IDLE, SETUP, ACCESS.
  - IDLE: PSEL=0, PENABLE=0. transfer=1 → SETUP, else stay.
  - SETUP: PSEL=1, PENABLE=0. Always → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Slaves are zero-wait (PREADY=1). Transfer completes; transfer=1 → SETUP, else IDLE.
- On each edge entering SETUP, the master registers PWRITE = ~READ_WRITE, PADDR = READ_WRITE ? apb_read_paddr : apb_write_paddr, PWDATA = apb_write_data. These are held stable through ACCESS.
- Slave select: PSEL1 = PSEL & ~PADDR[8], PSEL2 = PSEL & PADDR[8]; exactly one slave active per transfer.
- Slave write: at the edge ending ACCESS with PWRITE=1, mem[PADDR[7:0]] ← PWDATA and valid[PADDR[7:0]] ← 1. PSLVERR=0.
- Slave read: PRDATA = mem[PADDR[7:0]] combinationally during ACCESS. PSLVERR=1 if valid bit of that entry is 0 (location never written since reset); PRDATA is then 0x00.
- At the edge ending ACCESS: PSLVERR output ← selected slave's error. On a read, apb_read_data_out ← PRDATA. On a write, apb_read_data_out holds.
- Outputs hold between transfers.

## Timing
- Reset (PRESETn=0 at an edge): state=IDLE, PSLVERR=0, apb_read_data_out=0x00, all valid bits cleared. Memory contents are not reset. Same for reset mid-transfer: an in-flight write is dropped.
- Transfer = 2 cycles (SETUP + ACCESS). Continuous transfer=1 gives one transfer every 2 cycles, with inputs sampled on every second edge.
- Latency: inputs sampled at edge N (entry to SETUP). Memory updated and outputs valid after edge N+2.
- transfer dropped during SETUP: the ACCESS still completes. transfer is only examined in IDLE and ACCESS.
- Direction may change between transfers. Read-after-write to the same address in consecutive transfers returns the new data.
- Address values ≥ 512 are truncated to 9 bits by the port width.

## Structure
- Shared package `apb_pkg`: state enum (IDLE/SETUP/ACCESS), ADDR_W=9, DATA_W=8, MEM_DEPTH=256.
- Sub-module `apb_slave` (memory + valid array + PRDATA/PSLVERR/PREADY), instantiated twice. Master FSM and muxing live in the top.

## Test plan
- Reset then write slave 1 addresses 0..7 with data 2·i (transfer held high) → one write per 2 cycles, PSLVERR=0 throughout.
- Write slave 2 addresses 0x100..0x107 with data i; read back 0x100..0x107 → apb_read_data_out = 0..7, PSLVERR=0.
- Read slave 1 addresses 0..7 after a reset that follows the writes → PSLVERR=1, data 0x00 (valid bits cleared).
- Write 0x00E=0x09, then read 0x00E → 0x09. Read 0x02D (never written) → PSLVERR=1, apb_read_data_out=0x00.
- Assert PRESETn=0 during ACCESS of a write to 0x016 → write not committed; a later read of 0x016 gives PSLVERR=1.
- Set transfer=1 with READ_WRITE=0 and no prior writes, then read the same address → PSLVERR=0 on write, read returns written value. transfer=0 → FSM returns to IDLE and outputs hold.
